ps2_transmitter: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte (LED set, reset, typematic, ...) from the CPU to the keyboard. It runs on the same `clk`/`clk0` sampling strobe and `tim_clk` timeout tick as the PS/2 receive path. It shares the open-collector CLOCK/DATA lines with that receive path and drives them low only through output enables. While it is active, `ps2_tx_busy` tells the top level to hold the receiver in reset so it ignores host-generated edges.

---
 rtl/ps2_transmitter_if.sv | 14 +
 rtl/ps2_transmitter.sv | 161 ++++++++++++++++
 tb/tb_ps2_transmitter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_transmitter_if.sv
// CPU-side command/status bundle of the PS/2 host-to-device transmitter.
interface ps2_transmitter_if;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       ps2_ack;
   logic       ps2_tx_busy;
   logic       ps2_tx_done;
   logic [1:0] ps2_tx_err;

   modport master (output tx_data, tx_start, ps2_ack,
                   input  ps2_tx_busy, ps2_tx_done, ps2_tx_err);
   modport slave  (input  tx_data, tx_start, ps2_ack,
                   output ps2_tx_busy, ps2_tx_done, ps2_tx_err);
endinterface

// File: rtl/ps2_transmitter.sv
// PS/2 host-to-device byte transmitter: inhibit, start bit, 11-fall clocked frame,
// ack check and line-release wait, all paced by the clk0 strobe.
module ps2_transmitter #(
   parameter int INHIBIT_TICKS = 112,
   parameter int START_TICKS   = 13889,
   parameter int FRAME_TICKS   = 1852
) (
   input  logic             clk,
   input  logic             n_res,
   input  logic             clk0,
   input  logic             tim_clk,
   input  logic             ps2_clock,
   input  logic             ps2_data,
   output logic             ps2_clock_oe,
   output logic             ps2_data_oe,
   ps2_transmitter_if.slave bus
);
   typedef enum logic [2:0] {IDLE, INHIBIT, START, SEND, ACK, WAIT_REL, DONE} state_t;

   localparam logic [13:0] INH_T = 14'(INHIBIT_TICKS);
   localparam logic [13:0] STT_T = 14'(START_TICKS);
   localparam logic [13:0] FRM_T = 14'(FRAME_TICKS);

   state_t      state_q, state_d;
   logic [1:0]  klatch_q, klatch_d;
   logic [9:0]  shift_q, shift_d;
   logic [13:0] tick_q, tick_d, tick_inc;
   logic [3:0]  fall_q, fall_d;
   logic        clk_oe_q, clk_oe_d, data_oe_q, data_oe_d, done_q, done_d;
   logic [1:0]  err_q, err_d;
   logic        fall, fin;
   logic [1:0]  fin_err;

   assign fall     = (klatch_q == 2'b10);
   assign tick_inc = (tim_clk && tick_q != '1) ? tick_q + 14'd1 : tick_q;

   always_comb begin
      state_d   = state_q;
      klatch_d  = klatch_q;
      shift_d   = shift_q;
      tick_d    = tick_q;
      fall_d    = fall_q;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;
      done_d    = done_q;
      err_d     = err_q;
      fin       = 1'b0;
      fin_err   = 2'b00;
      if (clk0) begin
         klatch_d = {klatch_q[0], ps2_clock};
         tick_d   = tick_inc;
         if (bus.ps2_ack) begin
            done_d = 1'b0;
            err_d  = 2'b00;
         end
         unique case (state_q)
            IDLE: if (bus.tx_start) begin
               shift_d   = {1'b1, ~^bus.tx_data, bus.tx_data};
               tick_d    = '0;
               fall_d    = '0;
               clk_oe_d  = 1'b1;
               data_oe_d = 1'b0;
               state_d   = INHIBIT;
            end
            // data_oe doubles as the "start bit already driven" flag
            INHIBIT: if (data_oe_q) begin
               clk_oe_d = 1'b0;
               tick_d   = '0;
               state_d  = START;
            end else if (tick_inc >= INH_T) begin
               data_oe_d = 1'b1;
            end
            START: if (fall) begin
               data_oe_d = ~shift_q[0];
               shift_d   = {1'b1, shift_q[9:1]};
               fall_d    = 4'd1;
               tick_d    = '0;
               state_d   = SEND;
            end else if (tick_inc >= STT_T) begin
               fin     = 1'b1;
               fin_err = 2'b10;
            end
            SEND: if (fall) begin
               data_oe_d = ~shift_q[0];
               shift_d   = {1'b1, shift_q[9:1]};
               fall_d    = fall_q + 4'd1;
               if (fall_q == 4'd9) begin
                  tick_d  = '0;
                  state_d = ACK;
               end
            end else if (tick_inc >= FRM_T) begin
               fin     = 1'b1;
               fin_err = 2'b11;
            end
            ACK: if (fall) begin
               if (!ps2_data) begin
                  tick_d  = '0;
                  state_d = WAIT_REL;
               end else begin
                  fin     = 1'b1;
                  fin_err = 2'b01;
               end
            end else if (tick_inc >= FRM_T) begin
               fin     = 1'b1;
               fin_err = 2'b11;
            end
            WAIT_REL: if (ps2_clock && ps2_data) begin
               fin     = 1'b1;
               fin_err = 2'b00;
            end else if (tick_inc >= FRM_T) begin
               fin     = 1'b1;
               fin_err = 2'b11;
            end
            DONE: begin
               tick_d  = '0;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
         // completion overrides a same-cycle ps2_ack clear
         if (fin) begin
            state_d   = DONE;
            done_d    = 1'b1;
            err_d     = fin_err;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            tick_d    = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge n_res) begin
      if (!n_res) begin
         state_q   <= IDLE;
         klatch_q  <= 2'b11;
         shift_q   <= '0;
         tick_q    <= '0;
         fall_q    <= '0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 2'b00;
      end else begin
         state_q   <= state_d;
         klatch_q  <= klatch_d;
         shift_q   <= shift_d;
         tick_q    <= tick_d;
         fall_q    <= fall_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign ps2_clock_oe    = clk_oe_q;
   assign ps2_data_oe     = data_oe_q;
   assign bus.ps2_tx_busy = (state_q != IDLE);
   assign bus.ps2_tx_done = done_q;
   assign bus.ps2_tx_err  = err_q;
endmodule

// File: tb/tb_ps2_transmitter.sv
// Bench for ps2_transmitter: keyboard line model, scoreboard of expected results,
// decoupled done monitor and inhibit-timing monitor.
module tb_ps2_transmitter;
   localparam int INH = 112, STT = 300, FRT = 400, H = 20;
   localparam int M_ACK = 0, M_NOACK = 1, M_NOCLK = 2, M_STALL = 3, M_RESET = 4;

   logic clk = 1'b0, n_res = 1'b1, clk0 = 1'b0, tim_clk = 1'b0;
   logic kb_clk_low = 1'b0, kb_data_low = 1'b0;
   logic ps2_clock, ps2_data, ps2_clock_oe, ps2_data_oe;

   ps2_transmitter_if bus();

   ps2_transmitter #(.INHIBIT_TICKS(INH), .START_TICKS(STT), .FRAME_TICKS(FRT)) dut (
      .clk(clk), .n_res(n_res), .clk0(clk0), .tim_clk(tim_clk),
      .ps2_clock(ps2_clock), .ps2_data(ps2_data),
      .ps2_clock_oe(ps2_clock_oe), .ps2_data_oe(ps2_data_oe), .bus(bus));

   // open-collector lines: either side may pull low
   assign ps2_clock = ~(ps2_clock_oe | kb_clk_low);
   assign ps2_data  = ~(ps2_data_oe | kb_data_low);

   typedef struct { logic [1:0] err; bit has_frame; logic [10:0] frame; } exp_t;
   exp_t exp_q[$];
   logic [10:0] kb_frame = '0;
   int checks = 0, errors = 0;
   int unsigned tick_total = 0;

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         #2;
         clk0    = ~clk0;
         tim_clk = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         if (n_res && clk0 && tim_clk) tick_total++;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: event did not occur within its bound", nm);
   endtask

   // Frame as the keyboard should see it: start 0, data LSB first, odd parity, stop 1
   function automatic logic [10:0] frame_of(input logic [7:0] d);
      int ones;
      ones = $countones(d);
      return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
   endfunction

   // Inhibit monitor: CLOCK low for INH qualified ticks + 1 clk0 cycle, start bit one cycle early
   initial begin
      bit act, pc0, ptk, pdo, do_last;
      int tk, tk_prev;
      act = 0; pc0 = 0; ptk = 0; pdo = 0; do_last = 0; tk = 0; tk_prev = 0;
      forever begin
         @(negedge clk);
         if (!n_res) act = 0;
         else if (!act) begin
            if (ps2_clock_oe) begin
               act = 1; tk = 0; tk_prev = 0; do_last = 0;
            end
         end else if (!ps2_clock_oe) begin
            chk("inhibit_ticks", 32'(tk), 32'(INH));
            chk("inhibit_reached_prev_cycle", 32'(tk_prev < INH), 32'd1);
            chk("start_bit_lead", 32'({pdo, do_last}), 32'b10);
            act = 0;
         end else if (pc0) begin
            tk_prev = tk;
            tk += int'(ptk);
            do_last = pdo;
         end
         pc0 = clk0;
         ptk = clk0 & tim_clk;
         pdo = ps2_data_oe;
      end
   end

   // Done monitor: pops the scoreboard on each rising done
   initial begin
      bit pd, c;
      exp_t e;
      pd = 0;
      forever begin
         @(negedge clk);
         if (n_res && bus.ps2_tx_done && !pd) begin
            if (exp_q.size() == 0) fail("unexpected_done");
            else begin
               e = exp_q.pop_front();
               chk("done_err", 32'(bus.ps2_tx_err), 32'(e.err));
               chk("done_oe_released", 32'({ps2_clock_oe, ps2_data_oe}), 32'd0);
               chk("busy_at_done", 32'(bus.ps2_tx_busy), 32'd1);
               if (e.has_frame) chk("frame_bits", 32'(kb_frame), 32'(e.frame));
               c = 0;
               for (int k = 0; k < 4 && !c; k++) begin
                  c = clk0;
                  @(negedge clk);
               end
               chk("busy_after_done", 32'(bus.ps2_tx_busy), 32'd0);
            end
         end
         pd = bus.ps2_tx_done;
      end
   end

   task automatic pulse_start(input logic [7:0] d, input bit expect_go);
      int k;
      k = 0;
      do begin @(negedge clk); k++; end while (!clk0 && k < 4);
      bus.tx_data  = d;
      bus.tx_start = 1'b1;
      @(negedge clk);
      bus.tx_start = 1'b0;
      if (expect_go) chk("start_latency", 32'(ps2_clock_oe), 32'd1);
   endtask

   task automatic pulse_ack();
      int k;
      k = 0;
      do begin @(negedge clk); k++; end while (!clk0 && k < 4);
      bus.ps2_ack = 1'b1;
      @(negedge clk);
      bus.ps2_ack = 1'b0;
   endtask

   task automatic wait_sig(input string nm, input int which, input bit val, input int bound,
                           output bit ok);
      ok = 0;
      for (int k = 0; k < bound; k++) begin
         @(negedge clk);
         if (((which == 0) ? ps2_clock_oe : bus.ps2_tx_done) == val) begin
            ok = 1;
            break;
         end
      end
      if (!ok) fail(nm);
   endtask

   task automatic ack_check();
      repeat (10) @(negedge clk);
      pulse_ack();
      chk("ack_clears", 32'({bus.ps2_tx_done, bus.ps2_tx_err}), 32'd0);
   endtask

   task automatic xfer(input logic [7:0] d, input int mode, input int nf, input bit poke,
                       input bit keep);
      exp_t e;
      bit ok;
      int unsigned mark;
      if (mode != M_RESET) begin
         case (mode)
            M_ACK:   e.err = 2'b00;
            M_NOACK: e.err = 2'b01;
            M_NOCLK: e.err = 2'b10;
            default: e.err = 2'b11;
         endcase
         e.has_frame = (mode == M_ACK || mode == M_NOACK);
         e.frame     = frame_of(d);
         exp_q.push_back(e);
      end
      pulse_start(d, 1'b1);
      if (keep) begin
         chk("done_kept_on_start", 32'(bus.ps2_tx_done), 32'd1);
         chk("err_kept_on_start", 32'(bus.ps2_tx_err), 32'b01);
         pulse_ack();
         chk("ack_mid_frame", 32'({bus.ps2_tx_done, bus.ps2_tx_err}), 32'd0);
      end
      wait_sig("inhibit_release", 0, 1'b0, 2000, ok);
      if (!ok) return;
      mark = tick_total;
      if (mode == M_NOCLK) begin
         wait_sig("start_timeout_done", 1, 1'b1, 5000, ok);
         if (ok) chk("start_timeout_ticks", tick_total - mark, 32'(STT));
         return;
      end
      repeat (4) @(negedge clk);
      kb_frame[0] = ps2_data;
      for (int i = 1; i <= 11; i++) begin
         if (mode == M_STALL && i > nf) break;
         if (i == 11) kb_data_low = (mode == M_ACK);
         kb_clk_low = 1'b1;
         if (mode == M_RESET && i == nf) begin
            repeat (8) @(negedge clk);
            n_res = 1'b0;
            #1;
            chk("reset_mid_oe", 32'({ps2_clock_oe, ps2_data_oe}), 32'd0);
            chk("reset_mid_status", 32'({bus.ps2_tx_busy, bus.ps2_tx_done, bus.ps2_tx_err}), 32'd0);
            repeat (4) @(negedge clk);
            kb_clk_low = 1'b0;
            repeat (4) @(negedge clk);
            n_res = 1'b1;
            return;
         end
         if (poke && i == 3) begin
            pulse_start(~d, 1'b0);
            repeat (H - 4) @(negedge clk);
         end else begin
            repeat (H) @(negedge clk);
         end
         kb_clk_low = 1'b0;
         @(negedge clk);
         if (i <= 10) kb_frame[i] = ps2_data;
         repeat (H - 1) @(negedge clk);
         if (i == 11) kb_data_low = 1'b0;
      end
      wait_sig("done_rise", 1, 1'b1, 5000, ok);
   endtask

   initial begin
      bus.tx_data  = '0;
      bus.tx_start = 1'b0;
      bus.ps2_ack  = 1'b0;
      #1 n_res = 1'b0;
      #1;
      chk("reset_state", 32'({ps2_clock_oe, ps2_data_oe, bus.ps2_tx_busy, bus.ps2_tx_done,
                              bus.ps2_tx_err}), 32'd0);
      repeat (4) @(negedge clk);
      n_res = 1'b1;
      repeat (4) @(negedge clk);
      chk("idle_after_reset", 32'({ps2_clock_oe, ps2_data_oe, bus.ps2_tx_busy,
                                   bus.ps2_tx_done}), 32'd0);

      xfer(8'hED, M_ACK, 0, 1'b1, 1'b0);
      ack_check();
      xfer(8'hED, M_NOACK, 0, 1'b0, 1'b0);
      xfer(8'($urandom), M_NOCLK, 0, 1'b0, 1'b1);
      ack_check();
      xfer(8'($urandom), M_STALL, 5, 1'b0, 1'b0);
      ack_check();
      for (int n = 0; n < 6; n++) begin
         xfer(8'($urandom), ($urandom_range(0, 3) == 0) ? M_NOACK : M_ACK, 0, 1'b0, 1'b0);
         ack_check();
      end
      // leave a no-ack result pending so the mid-frame reset has something to clear
      xfer(8'($urandom), M_NOACK, 0, 1'b0, 1'b0);
      xfer(8'($urandom), M_RESET, 6, 1'b0, 1'b0);
      xfer(8'hFF, M_ACK, 0, 1'b0, 1'b0);
      ack_check();

      repeat (20) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
